// File: rtl/bus_sequencer.sv
// -----------------------------------------------------------------------------
// bus_sequencer
//   Power-on reset sequencer, address decoder and bus-cycle (DTACK/BERR)
//   generator for a 68000-style CPU with boot PROM and SRAM.
//
//   After NRESET_IN releases, RESET/HALT stay high for RESET_CYCLES clocks,
//   then RUN rises. While running, a strobed access is decoded into
//   PROM/SRAM chip selects. The bus FSM acknowledges it after a per-region
//   number of wait states, or signals BERR for an unmapped address. The
//   first write into the lower region ends boot mode. After that, lower
//   reads come from SRAM instead of PROM.
//
// Ports
//   CPUCLK_IN           in   sole clock, rising edge
//   NRESET_IN           in   asynchronous active-low reset
//   AS_IN/UDS_IN/LDS_IN in   active-high address / data strobes
//   WR_IN               in   1 = write cycle
//   STEPEN_IN, STEP_IN  in   single-step enable and step button
//   ADDR_IN[23:0]       in   CPU address
//   RESET, HALT, RUN    out  registered reset-sequencer outputs
//   DTACK, BERR         out  registered bus-cycle termination
//   PROMCS0/1, SRAMCS0/1, OE  out  combinational selects (0 = UDS, 1 = LDS)
//   BOOTSTRAPPED        out  registered, set by first lower-region write
//   STATE_DBG_O[2:0]    out  current bus FSM state
//
// Handshake: DTREQ (RUN & AS & (UDS|LDS)) is the request and stays high
//   until the cycle ends. DTACK or BERR is the response and is held until
//   DTREQ drops. If DTREQ drops before a response, the cycle is abandoned.
// -----------------------------------------------------------------------------
module bus_sequencer #(
  parameter int unsigned RESET_CYCLES = 10000,
  parameter int unsigned PROM_WAIT    = 2,
  parameter int unsigned SRAM_WAIT    = 0,
  parameter int unsigned BERR_CYCLES  = 64
) (
  input  logic        CPUCLK_IN,
  input  logic        NRESET_IN,
  input  logic        AS_IN,
  input  logic        UDS_IN,
  input  logic        LDS_IN,
  input  logic        WR_IN,
  input  logic        STEPEN_IN,
  input  logic        STEP_IN,
  input  logic [23:0] ADDR_IN,
  output logic        RESET,
  output logic        HALT,
  output logic        RUN,
  output logic        DTACK,
  output logic        BERR,
  output logic        PROMCS0,
  output logic        PROMCS1,
  output logic        SRAMCS0,
  output logic        SRAMCS1,
  output logic        OE,
  output logic        BOOTSTRAPPED,
  output logic [2:0]  STATE_DBG_O
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_STEP  = 3'd2,
    S_ACK   = 3'd3,
    S_PAUSE = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [19:0] RST_END = 20'(RESET_CYCLES);
  localparam logic [7:0]  PW      = 8'(PROM_WAIT);
  localparam logic [7:0]  SW      = 8'(SRAM_WAIT);
  localparam logic [7:0]  BW      = 8'(BERR_CYCLES);

  // ---------------------------------------------------------------------------
  // Reset sequencer
  // ---------------------------------------------------------------------------
  logic [19:0] rst_cnt_q, rst_cnt_d;
  logic        run_q, run_d;
  logic        hold_q, hold_d;

  always_comb begin
    rst_cnt_d = rst_cnt_q;
    run_d     = run_q;
    // The counter freezes once RUN is up, so it never wraps.
    if (!run_q) begin
      rst_cnt_d = rst_cnt_q + 20'd1;
      if (rst_cnt_d == RST_END) run_d = 1'b1;
    end
    hold_d = ~run_d;
  end

  // ---------------------------------------------------------------------------
  // Address decode and chip selects
  // ---------------------------------------------------------------------------
  logic boot_q, boot_d;
  logic lower, upper, unmapped;
  logic prom_sel, sram_sel;
  logic asreq, dtreq;

  always_comb begin
    lower    = (ADDR_IN[23:20] == 4'h0);
    upper    = (ADDR_IN[23:20] == 4'hF);
    unmapped = ~lower & ~upper;
    prom_sel = upper | (lower & ~WR_IN & ~boot_q);
    sram_sel = lower & (WR_IN | boot_q);
    asreq    = run_q & AS_IN;
    dtreq    = asreq & (UDS_IN | LDS_IN);
  end

  assign PROMCS0 = asreq & prom_sel & UDS_IN;
  assign PROMCS1 = asreq & prom_sel & LDS_IN;
  assign SRAMCS0 = asreq & sram_sel & UDS_IN;
  assign SRAMCS1 = asreq & sram_sel & LDS_IN;
  assign OE      = asreq & (prom_sel | sram_sel) & ~WR_IN;

  // ---------------------------------------------------------------------------
  // Bus-cycle FSM
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        stepen_q, stepen_d;
  logic        unmap_q, unmap_d;
  logic        dtack_q, dtack_d;
  logic        berr_q, berr_d;
  logic [7:0]  load_val;
  state_t      tgt_live, tgt_latched;

  always_comb begin
    load_val    = unmapped ? BW : (prom_sel ? PW : SW);
    tgt_live    = unmapped ? S_ERR : (STEPEN_IN ? S_STEP : S_ACK);
    tgt_latched = unmap_q  ? S_ERR : (stepen_q  ? S_STEP : S_ACK);
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    stepen_d = stepen_q;
    unmap_d  = unmap_q;
    boot_d   = boot_q;

    unique case (state_q)
      S_IDLE: begin
        if (dtreq) begin
          stepen_d = STEPEN_IN;
          unmap_d  = unmapped;
          // Unmapped writes are excluded because they are not LOWER.
          if (lower && WR_IN) boot_d = 1'b1;
          // A zero wait count skips WAIT so the response comes one edge
          // after the request is first seen. In general it comes on edge N+1.
          if (load_val == 8'd0) begin
            state_d = tgt_live;
          end else begin
            wait_d  = load_val;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 8'd1;
        if (!dtreq) begin
          state_d = S_IDLE;
        end else if (wait_q <= 8'd1) begin
          state_d = tgt_latched;
        end
      end
      S_STEP: begin
        if (!dtreq)       state_d = S_IDLE;
        else if (STEP_IN) state_d = S_ACK;
      end
      S_ACK: begin
        // With a held step button, PAUSE makes sure one press completes
        // only one bus cycle.
        if (!dtreq) state_d = (stepen_q && STEP_IN) ? S_PAUSE : S_IDLE;
      end
      S_PAUSE: begin
        if (!STEP_IN) state_d = S_IDLE;
      end
      S_ERR: begin
        if (!dtreq) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Responses are registered from the next state. This keeps DTACK and
    // BERR mutually exclusive and free of glitches.
    dtack_d = (state_d == S_ACK);
    berr_d  = (state_d == S_ERR);
  end

  always_ff @(posedge CPUCLK_IN or negedge NRESET_IN) begin
    if (!NRESET_IN) begin
      rst_cnt_q <= '0;
      run_q     <= 1'b0;
      hold_q    <= 1'b1;
      state_q   <= S_IDLE;
      wait_q    <= '0;
      stepen_q  <= 1'b0;
      unmap_q   <= 1'b0;
      dtack_q   <= 1'b0;
      berr_q    <= 1'b0;
      boot_q    <= 1'b0;
    end else begin
      rst_cnt_q <= rst_cnt_d;
      run_q     <= run_d;
      hold_q    <= hold_d;
      state_q   <= state_d;
      wait_q    <= wait_d;
      stepen_q  <= stepen_d;
      unmap_q   <= unmap_d;
      dtack_q   <= dtack_d;
      berr_q    <= berr_d;
      boot_q    <= boot_d;
    end
  end

  assign RESET        = hold_q;
  assign HALT         = hold_q;
  assign RUN          = run_q;
  assign DTACK        = dtack_q;
  assign BERR         = berr_q;
  assign BOOTSTRAPPED = boot_q;
  assign STATE_DBG_O  = state_q;

endmodule
